seven_seg_scheduler: RTL and testbench
======================================

// Module: seven_seg_scheduler
// PURPOSE
//  Time-shares the Basys 3 four-digit display between N_SRC independent producers.
//  - Each producer posts a signed 11-bit value into its own holding slot.
//  - The scheduler rotates round-robin through the occupied slots, holding each for DWELL_MS.
//  - It drives the data/enable inputs of the seven-segment display driver.
//  - It sits between the application logic and the display driver.
// PARAMETERS
//  I_CLK_FRQ  100_000_000  i_clk frequency in Hz
//  N_SRC      4            number of producers/slots, 2..8
//  DWELL_MS   1000         display time per occupied slot, in ms, >=1
// PORTS
//  i_clk     in   1          system clock
//  i_rst_n   in   1          asynchronous, active-low reset
//  i_post    in   N_SRC      bit k: capture i_data[k] into slot k this cycle
//  i_clr     in   N_SRC      bit k: mark slot k empty
//  i_data    in   N_SRC*11   packed signed values; slot k = [11k+10:11k]
//  o_ack     out  N_SRC      bit k: one-cycle pulse, the cycle after slot k captured
//  o_data    out  11         signed value for the display driver's data input
//  o_en      out  1          level; high while any slot is occupied
//  o_src     out  3          index of the slot being shown (0 when idle)
// BEHAVIOUR
//  - Reset (async assert, sync deassert inside the block):
//    all slots empty, slot data 0, o_ack=0, o_data=0, o_en=0, o_src=0, state=IDLE.
//  - Capture: i_post[k]=1 at edge t -> slot k valid, data latched; o_ack[k]=1 during cycle t+1.
//    - Posts to different slots in the same cycle are all accepted.
//    - i_post[k] and i_clr[k] together: the post wins.
//  - Dwell: DWELL_CYC = (I_CLK_FRQ/1000)*DWELL_MS.
//    - Counter width is $clog2(DWELL_CYC+1).
//    - The counter reloads on every slot switch.
//  - FSM:
//    - IDLE: o_en=0. Any valid slot -> ADV.
//    - ADV, one cycle: pick the first valid slot after o_src in round-robin order, wrapping N_SRC-1 -> 0.
//      - The search includes o_src itself last.
//      - Set o_src, load the counter, go to SHOW.
//      - No valid slot -> IDLE.
//    - SHOW: o_en=1, o_data = slot[o_src] data (registered, 1-cycle latency from capture).
//      - Counter decrements each cycle.
//      - Counter reaches 0 -> ADV.
//      - Slot o_src cleared -> ADV next cycle without waiting for the dwell.
//  - Only one slot occupied: ADV reselects it. o_src and o_data are unchanged and no visible glitch occurs.
//  - A re-post to the shown slot updates o_data on the next cycle and does not restart the dwell.
//  - Mid-operation reset returns everything to the reset values at once. In-flight acks are dropped.
//  - o_en stays high across ADV whenever some slot remains valid. The driver samples the enable only at its refresh strobe.
// CONFIGURATION
//  SEVEN_SEG_SCHED_PREEMPT_EN
//  - Defined: a post to slot 0 while in SHOW with o_src!=0 forces o_src=0 on the next cycle and reloads the counter.
//    - Slot 0 is the alarm/priority source.
//    - Rotation then resumes from slot 0.
//  - Undefined: slot 0 waits for its round-robin turn like any other slot.
// STRUCTURE
//  - Shared package/header seven_seg_defs:
//    - SEG_DATA_W=11, signed display range constants.
//    - FSM state encodings IDLE=2'd0, ADV=2'd1, SHOW=2'd2.
//  - Sub-module rr_next_valid, combinational:
//    - inputs: valid mask and current index; outputs: next index and found flag.
//    - Also reusable by other arbiters in the codebase.
// TESTING (bench uses I_CLK_FRQ=1000, DWELL_MS=5 -> DWELL_CYC=5, N_SRC=4)
//  - Reset with i_rst_n=0 mid-SHOW -> o_en=0, o_data=0, o_src=0 immediately; all slots read empty after release.
//  - Post slot 2 = -7 -> o_ack[2] pulses 1 cycle; o_en rises, o_src=2, o_data=-7, held indefinitely.
//  - Post 1 = 12, 3 = 345 together -> both acked in the same cycle; display alternates 12 and 345, 5 cycles each; 1 ADV cycle per switch.
//  - While slot 3 is shown, clear slot 3 -> o_src=1 within 2 cycles; clearing slot 1 too -> IDLE, o_en=0.
//  - Same-cycle post and clear on slot 1 = 99 -> slot stays valid with 99, acked.
//  - PREEMPT_EN defined, showing slot 2, post slot 0 = 1023 -> next cycle o_src=0, o_data=1023, full 5-cycle dwell.
//  - PREEMPT_EN undefined, same stimulus -> slot 0 shown only after slot 2's dwell expires.

Source files
------------

// File: rtl/seven_seg_scheduler_pkg.sv
// Shared definitions for the seven-segment display scheduler and its helpers:
// display data width, signed display range and scheduler state encodings.
package seven_seg_defs;

   localparam int SEG_DATA_W = 11;
   localparam int SRC_W      = 3;

   localparam logic signed [SEG_DATA_W-1:0] SEG_DATA_MIN = 11'sh400;
   localparam logic signed [SEG_DATA_W-1:0] SEG_DATA_MAX = 11'sh3FF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADV  = 2'd1,
      SHOW = 2'd2
   } sched_state_t;

endpackage

// File: rtl/seven_seg_scheduler_rr_next_valid.sv
// Combinational round-robin search: first valid index after cur, wrapping,
// with cur itself considered last. Usable by any mask-based arbiter.
module rr_next_valid #(
   parameter int N     = 4,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] cur,
   output logic [IDX_W-1:0] next_idx,
   output logic             found
);

   logic [IDX_W-1:0] cand [N];
   logic [N-1:0]     hit;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_off
         // Candidate at offset gi+1 from cur, reduced modulo N
         logic [IDX_W:0] sum;
         assign sum       = {1'b0, cur} + (IDX_W+1)'(gi + 1);
         assign cand[gi]  = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                   : sum[IDX_W-1:0];
         assign hit[gi]   = |(valid & (N'(1) << cand[gi]));
      end
   endgenerate

   // Walk offsets from farthest to nearest so the nearest hit wins
   always_comb begin
      next_idx = '0;
      found    = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (hit[i]) begin
            next_idx = cand[i];
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seven_seg_scheduler.sv
// Round-robin time-sharing of the four-digit display among N_SRC producers.
// Define SEVEN_SEG_SCHED_PREEMPT_EN to let posts to slot 0 preempt the display.
module seven_seg_scheduler
   import seven_seg_defs::*;
#(
   parameter int I_CLK_FRQ = 100_000_000,
   parameter int N_SRC     = 4,
   parameter int DWELL_MS  = 1000
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [N_SRC-1:0]              i_post,
   input  logic [N_SRC-1:0]              i_clr,
   input  logic [N_SRC*SEG_DATA_W-1:0]   i_data,
   output logic [N_SRC-1:0]              o_ack,
   output logic signed [SEG_DATA_W-1:0]  o_data,
   output logic                          o_en,
   output logic [SRC_W-1:0]              o_src
);

   localparam int DWELL_CYC = (I_CLK_FRQ / 1000) * DWELL_MS;
   localparam int CNT_W     = $clog2(DWELL_CYC + 1);
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYC - 1);

`ifdef SEVEN_SEG_SCHED_PREEMPT_EN
   localparam bit PREEMPT_EN = 1'b1;
`else
   localparam bit PREEMPT_EN = 1'b0;
`endif

   // Reset asserts asynchronously, releases two clocks after i_rst_n rises
   logic [1:0] rst_sync_reg;
   logic       rst_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rst_sync_reg <= 2'b00;
      else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_n = rst_sync_reg[1];

   logic [N_SRC-1:0]             valid_reg, valid_next;
   logic [N_SRC-1:0]             ack_reg;
   logic signed [SEG_DATA_W-1:0] data_next [N_SRC];

   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_slot
         logic signed [SEG_DATA_W-1:0] data_reg;
         assign valid_next[gi] = i_post[gi] | (valid_reg[gi] & ~i_clr[gi]);
         assign data_next[gi]  = i_post[gi] ? i_data[gi*SEG_DATA_W +: SEG_DATA_W] : data_reg;

         always_ff @(posedge i_clk or negedge rst_n) begin
            if (!rst_n) data_reg <= '0;
            else        data_reg <= data_next[gi];
         end
      end
   endgenerate

   sched_state_t                 state_reg, state_next;
   logic [SRC_W-1:0]             src_reg, src_next;
   logic [CNT_W-1:0]             cnt_reg, cnt_next;
   logic                         en_reg, en_next;
   logic signed [SEG_DATA_W-1:0] out_reg, out_next;

   logic [SRC_W-1:0]             rr_idx;
   logic                         rr_found;
   logic signed [SEG_DATA_W-1:0] rr_data, src_data, slot0_data;
   logic                         src_still_valid;

   rr_next_valid #(
      .N     (N_SRC),
      .IDX_W (SRC_W)
   ) u_rr (
      .valid    (valid_reg),
      .cur      (src_reg),
      .next_idx (rr_idx),
      .found    (rr_found)
   );

   // Data forwarded from this cycle's posts so the display never lags a capture
   always_comb begin
      rr_data         = '0;
      src_data        = '0;
      src_still_valid = 1'b0;
      slot0_data      = data_next[0];
      for (int k = 0; k < N_SRC; k++) begin
         if (rr_idx == SRC_W'(k)) rr_data = data_next[k];
         if (src_reg == SRC_W'(k)) begin
            src_data        = data_next[k];
            src_still_valid = valid_next[k];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      src_next   = src_reg;
      cnt_next   = cnt_reg;
      en_next    = en_reg;
      out_next   = out_reg;
      case (state_reg)
         IDLE: begin
            if (|valid_reg) state_next = ADV;
         end
         ADV: begin
            if (rr_found) begin
               state_next = SHOW;
               src_next   = rr_idx;
               cnt_next   = DWELL_LOAD;
               en_next    = 1'b1;
               out_next   = rr_data;
            end else begin
               state_next = IDLE;
               src_next   = '0;
               en_next    = 1'b0;
               out_next   = '0;
            end
         end
         SHOW: begin
            if (PREEMPT_EN && i_post[0] && (src_reg != '0)) begin
               src_next = '0;
               cnt_next = DWELL_LOAD;
               out_next = slot0_data;
            end else if (!src_still_valid || (cnt_reg == '0)) begin
               state_next = ADV;
               en_next    = |valid_next;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
               out_next = src_data;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
         ack_reg   <= '0;
         state_reg <= IDLE;
         src_reg   <= '0;
         cnt_reg   <= '0;
         en_reg    <= 1'b0;
         out_reg   <= '0;
      end else begin
         valid_reg <= valid_next;
         ack_reg   <= i_post;
         state_reg <= state_next;
         src_reg   <= src_next;
         cnt_reg   <= cnt_next;
         en_reg    <= en_next;
         out_reg   <= out_next;
      end
   end

   assign o_ack  = ack_reg;
   assign o_data = out_reg;
   assign o_en   = en_reg;
   assign o_src  = src_reg;

endmodule

// File: tb/tb_seven_seg_scheduler.sv
// Self-checking bench for seven_seg_scheduler: directed scenarios plus random
// traffic against a behavioural model of the display schedule.
module tb_seven_seg_scheduler;

   localparam int N  = 4;
   localparam int W  = 11;
   localparam int DW = 5;
`ifdef SEVEN_SEG_SCHED_PREEMPT_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [N-1:0]        post = '0;
   logic [N-1:0]        clr = '0;
   logic [N*W-1:0]      data = '0;
   logic [N-1:0]        ack;
   logic signed [W-1:0] odata;
   logic                en;
   logic [2:0]          src;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seven_seg_scheduler #(
      .I_CLK_FRQ (1000),
      .N_SRC     (N),
      .DWELL_MS  (DW)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_post  (post),
      .i_clr   (clr),
      .i_data  (data),
      .o_ack   (ack),
      .o_data  (odata),
      .o_en    (en),
      .o_src   (src)
   );

   // Behavioural model: 0 = nothing shown, 1 = choosing next slot, 2 = showing
   bit       m_valid [N];
   int       m_slot  [N];
   int       m_phase;
   int       m_src;
   int       m_left;
   bit       m_en;
   int       m_dat;
   bit [N-1:0] m_ack;

   task automatic reset_model();
      for (int k = 0; k < N; k++) begin
         m_valid[k] = 1'b0;
         m_slot[k]  = 0;
      end
      m_phase = 0; m_src = 0; m_left = 0; m_en = 1'b0; m_dat = 0; m_ack = '0;
   endtask

   task automatic model_edge();
      bit nv [N];
      int nd [N];
      bit any_nv;
      bit any_v;
      int pick;
      any_nv = 1'b0;
      any_v  = 1'b0;
      for (int k = 0; k < N; k++) begin
         nv[k] = post[k] || (m_valid[k] && !clr[k]);
         nd[k] = post[k] ? int'($signed(data[k*W +: W])) : m_slot[k];
         any_nv |= nv[k];
         any_v  |= m_valid[k];
      end
      m_ack = post;
      if (m_phase == 0) begin
         if (any_v) m_phase = 1;
      end else if (m_phase == 1) begin
         pick = -1;
         for (int off = 1; off <= N; off++)
            if (pick < 0 && m_valid[(m_src + off) % N]) pick = (m_src + off) % N;
         if (pick >= 0) begin
            m_phase = 2; m_src = pick; m_left = DW - 1; m_en = 1'b1; m_dat = nd[pick];
         end else begin
            m_phase = 0; m_src = 0; m_en = 1'b0; m_dat = 0;
         end
      end else begin
         if (PRE && post[0] && m_src != 0) begin
            m_src = 0; m_left = DW - 1; m_dat = nd[0];
         end else if (!nv[m_src] || m_left == 0) begin
            m_phase = 1; m_en = any_nv;
         end else begin
            m_left = m_left - 1; m_dat = nd[m_src];
         end
      end
      m_valid = nv;
      m_slot  = nd;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst_n) reset_model();
      else        model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      post = '0; clr = '0; data = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (3) cycle();
   endtask

   task automatic test_reset();
      logic [W-1:0] exp_d;
      apply_reset();
      post[2] = 1'b1; data[2*W +: W] = 11'sd77;
      cycle();
      idle_inputs();
      for (int i = 0; i < 10 && !en; i++) cycle();
      repeat (2) cycle();
      n_tests++;
      if (en !== 1'b1) begin
         n_fail++; $display("FAIL reset_pre_show: en=%0b required 1", en);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (en !== 1'b0 || odata !== '0 || src !== 3'd0 || ack !== '0) begin
         n_fail++;
         $display("FAIL reset_async: en=%0b data=%0d src=%0d ack=%b required 0/0/0/0", en, odata, src, ack);
      end
      reset_model();
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (3) cycle();
      for (int i = 0; i < 6; i++) begin
         cycle();
         n_tests++;
         if (en !== 1'b0 || src !== 3'd0) begin
            n_fail++; $display("FAIL reset_empty: cycle %0d en=%0b src=%0d required 0/0", i, en, src);
         end
      end
      exp_d = '0;
      $display("[TB] test_reset done, data=%0d expected %0d", odata, $signed(exp_d));
   endtask

   task automatic test_single();
      apply_reset();
      post[2] = 1'b1; data[2*W +: W] = -11'sd7;
      cycle();
      idle_inputs();
      n_tests++;
      if (ack !== 4'b0100) begin
         n_fail++; $display("FAIL single_ack: ack=%b required 0100", ack);
      end
      cycle();
      n_tests++;
      if (ack !== 4'b0000) begin
         n_fail++; $display("FAIL single_ack_pulse: ack=%b required 0000", ack);
      end
      for (int i = 0; i < 6 && !en; i++) cycle();
      for (int i = 0; i < 20; i++) begin
         n_tests++;
         if (en !== 1'b1 || src !== 3'd2 || odata !== -11'sd7) begin
            n_fail++; $display("FAIL single_hold: cycle %0d en=%0b src=%0d data=%0d required 1/2/-7", i, en, src, odata);
         end
         cycle();
      end
      post[2] = 1'b1; data[2*W +: W] = -11'sd100;
      cycle();
      idle_inputs();
      n_tests++;
      if (odata !== -11'sd100 || src !== 3'd2 || en !== 1'b1) begin
         n_fail++; $display("FAIL single_repost: data=%0d src=%0d required -100/2", odata, src);
      end
      $display("[TB] test_single: src=%0d data=%0d", src, odata);
   endtask

   task automatic test_alternate();
      int exp_src;
      int exp_dat;
      apply_reset();
      post = 4'b1010; data[1*W +: W] = 11'sd12; data[3*W +: W] = 11'sd345;
      cycle();
      idle_inputs();
      n_tests++;
      if (ack !== 4'b1010) begin
         n_fail++; $display("FAIL alt_ack: ack=%b required 1010", ack);
      end
      for (int i = 0; i < 6 && !en; i++) cycle();
      for (int i = 0; i < 30; i++) begin
         exp_src = ((i / (DW + 1)) % 2 == 0) ? 1 : 3;
         exp_dat = (exp_src == 1) ? 12 : 345;
         n_tests++;
         if (en !== 1'b1 || src !== 3'(exp_src) || odata !== 11'(exp_dat)) begin
            n_fail++;
            $display("FAIL alt_rotate: cycle %0d en=%0b src=%0d data=%0d required 1/%0d/%0d", i, en, src, odata, exp_src, exp_dat);
         end
         cycle();
      end
      $display("[TB] test_alternate: final src=%0d", src);
   endtask

   task automatic test_clear();
      apply_reset();
      post = 4'b1010; data[1*W +: W] = 11'sd12; data[3*W +: W] = 11'sd345;
      cycle();
      idle_inputs();
      for (int i = 0; i < 20 && src !== 3'd3; i++) cycle();
      n_tests++;
      if (src !== 3'd3) begin
         n_fail++; $display("FAIL clear_reach3: src=%0d required 3", src);
      end
      clr = 4'b1000;
      cycle();
      clr = '0;
      n_tests++;
      if (en !== 1'b1) begin
         n_fail++; $display("FAIL clear_en_hold: en=%0b required 1", en);
      end
      cycle();
      n_tests++;
      if (src !== 3'd1 || odata !== 11'sd12 || en !== 1'b1) begin
         n_fail++; $display("FAIL clear_to1: src=%0d data=%0d en=%0b required 1/12/1", src, odata, en);
      end
      clr = 4'b0010;
      cycle();
      clr = '0;
      cycle();
      n_tests++;
      if (en !== 1'b0) begin
         n_fail++; $display("FAIL clear_idle: en=%0b required 0", en);
      end
      repeat (3) cycle();
      n_tests++;
      if (en !== 1'b0 || src !== 3'd0) begin
         n_fail++; $display("FAIL clear_stay_idle: en=%0b src=%0d required 0/0", en, src);
      end
      $display("[TB] test_clear: en=%0b src=%0d", en, src);
   endtask

   task automatic test_post_clear();
      apply_reset();
      post[1] = 1'b1; clr[1] = 1'b1; data[1*W +: W] = 11'sd99;
      cycle();
      idle_inputs();
      n_tests++;
      if (ack !== 4'b0010) begin
         n_fail++; $display("FAIL postclr_ack: ack=%b required 0010", ack);
      end
      for (int i = 0; i < 6 && !en; i++) cycle();
      n_tests++;
      if (en !== 1'b1 || src !== 3'd1 || odata !== 11'sd99) begin
         n_fail++; $display("FAIL postclr_show: en=%0b src=%0d data=%0d required 1/1/99", en, src, odata);
      end
      $display("[TB] test_post_clear: src=%0d data=%0d", src, odata);
   endtask

   task automatic test_preempt();
      int exp_src;
      int exp_dat;
      apply_reset();
      post[2] = 1'b1; data[2*W +: W] = 11'sd55;
      cycle();
      idle_inputs();
      for (int i = 0; i < 6 && !en; i++) cycle();
      cycle();
      post[0] = 1'b1; data[0 +: W] = 11'sd1023;
      cycle();
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         if (PRE) exp_src = (i < DW + 1) ? 0 : 2;
         else     exp_src = (i < 4) ? 2 : 0;
         exp_dat = (exp_src == 0) ? 1023 : 55;
         n_tests++;
         if (en !== 1'b1 || src !== 3'(exp_src) || odata !== 11'(exp_dat)) begin
            n_fail++;
            $display("FAIL preempt_seq: cycle %0d src=%0d data=%0d required %0d/%0d", i, src, odata, exp_src, exp_dat);
         end
         cycle();
      end
      $display("[TB] test_preempt (preempt=%0b): src=%0d", PRE, src);
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < N; k++) begin
            post[k] = ($urandom_range(0, 7) == 0);
            clr[k]  = ($urandom_range(0, 9) == 0);
            data[k*W +: W] = W'($urandom);
         end
         cycle();
         n_tests++;
         if (en !== m_en || src !== 3'(m_src) || odata !== W'(m_dat) || ack !== m_ack) begin
            n_fail++; errs++;
            if (errs < 10)
               $display("FAIL random_model: cycle %0d en=%0b src=%0d data=%0d ack=%b required %0b/%0d/%0d/%b",
                        i, en, src, odata, ack, m_en, m_src, m_dat, m_ack);
         end
      end
      idle_inputs();
      $display("[TB] test_random: 400 cycles, %0d differences", errs);
   endtask

   initial begin
      reset_model();
      test_reset();
      test_single();
      test_alternate();
      test_clear();
      test_post_clear();
      test_preempt();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
